// File: rtl/tcbm_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// tcbm_handshake_ctrl
//
// Device-side TCBM (1551-style) byte-transfer sequencer. Emulates the 6523
// port lines seen by the host: data on port A, status on port B[1:0] and the
// DAV/ACK handshake on port C[7:6]. A transfer starts with a code byte from
// the host, followed by one data byte moved host->device (0x81/0x83) or
// device->host (0x82, or status only for 0x84). The device side sees plain
// valid/ready byte streams.
//
// Handshake semantics (both device-side streams):
//   rx: a byte is transferred on every rising clock edge where
//       rx_valid=1 and rx_ready=1. rx_valid/rx_data/rx_is_cmd hold steady
//       until that edge; rx_ready may change freely.
//   tx: tx_data/tx_status are held by the device side while tx_valid=1; they
//       are sampled when the host has asked for a byte, and the byte is
//       popped by a single-cycle tx_ready pulse after the host releases DAV.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   tcbm_data_in       port A as driven by the host
//   tcbm_data_out/_oe  port A value and enable driven by the device
//   dav_in             host DAV (active-low, asynchronous to clock)
//   ack_out            device ACK (active-low)
//   status_out         port B[1:0] status to the host
//   rx_*               received byte stream (towards the device)
//   tx_*               byte stream to send to the host
//   busy               sequencer not in IDLE
//   err                one-cycle pulse on a bad code or handshake timeout
//
// Build option:
//   TCBM_TIMEOUT_EN    when defined, every wait on a host DAV edge is bounded
//                      by TIMEOUT_MAX cycles; the transfer is aborted with
//                      status 2'b10. Undefined: the block waits forever.
// -----------------------------------------------------------------------------
module tcbm_handshake_ctrl #(
   parameter int unsigned          TIMEOUT_W   = 16,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 16'hFFFF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tcbm_data_in,
   output logic [7:0] tcbm_data_out,
   output logic       tcbm_data_oe,
   input  logic       dav_in,
   output logic       ack_out,
   output logic [1:0] status_out,
   output logic [7:0] rx_data,
   output logic       rx_is_cmd,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic [1:0] tx_status,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CODE_REL = 3'd1,
      W_WAIT   = 3'd2,
      W_PUSH   = 3'd3,
      W_REL    = 3'd4,
      R_WAIT   = 3'd5,
      R_ACK    = 3'd6,
      R_REL    = 3'd7
   } state_t;

   state_t     state_q;
   logic       dav_meta_q;
   logic       dav_s_q;
   logic [7:0] code_q;
   logic       stat_only_q;   // 0x84: status-only read, no tx pop
   logic       ack_q;
   logic       oe_q;
   logic [7:0] dout_q;
   logic [1:0] status_q;
   logic [7:0] rx_data_q;
   logic       rx_cmd_q;
   logic       rx_valid_q;
   logic       tx_ready_q;
   logic       err_q;
   logic       tmo_hit;

   // Two-flop synchronizer for the asynchronous DAV pin. Reset to the
   // released (high) level so a reset never looks like a DAV assertion.
   always_ff @(posedge clock) begin
      if (reset) begin
         dav_meta_q <= 1'b1;
         dav_s_q    <= 1'b1;
      end else begin
         dav_meta_q <= dav_in;
         dav_s_q    <= dav_meta_q;
      end
   end

`ifdef TCBM_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] tmo_q;
   logic                 waiting;

   // Asserted only while the awaited DAV edge has not yet arrived. A state
   // is always left on a cycle where waiting is low, so clearing the counter
   // whenever waiting is low also clears it on every state change.
   always_comb begin
      waiting = 1'b0;
      case (state_q)
         CODE_REL: waiting = ~dav_s_q;
         W_WAIT:   waiting =  dav_s_q;
         W_REL:    waiting = ~dav_s_q;
         R_WAIT:   waiting =  dav_s_q;   // waiting on tx_valid never times out
         R_REL:    waiting = ~dav_s_q;
         default:  waiting = 1'b0;
      endcase
   end

   assign tmo_hit = waiting && (tmo_q == TIMEOUT_MAX);

   always_ff @(posedge clock) begin
      if (reset || !waiting || tmo_hit) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 1'b1;
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^{1'b0, TIMEOUT_MAX};
   assign tmo_hit    = 1'b0;
`endif

   // Sequencer. All port-facing outputs are registered here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         code_q      <= 8'h00;
         stat_only_q <= 1'b0;
         ack_q       <= 1'b1;
         oe_q        <= 1'b0;
         dout_q      <= 8'h00;
         status_q    <= 2'b00;
         rx_data_q   <= 8'h00;
         rx_cmd_q    <= 1'b0;
         rx_valid_q  <= 1'b0;
         tx_ready_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q      <= 1'b0;
         tx_ready_q <= 1'b0;
         if (tmo_hit) begin
            err_q      <= 1'b1;
            ack_q      <= 1'b1;
            oe_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            status_q   <= 2'b10;
            state_q    <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (!dav_s_q) begin
                     code_q  <= tcbm_data_in;
                     ack_q   <= 1'b0;
                     state_q <= CODE_REL;
                  end
               end
               CODE_REL: begin
                  if (dav_s_q) begin
                     ack_q <= 1'b1;
                     case (code_q)
                        8'h81: begin rx_cmd_q <= 1'b0; state_q <= W_WAIT; end
                        8'h83: begin rx_cmd_q <= 1'b1; state_q <= W_WAIT; end
                        8'h82: begin stat_only_q <= 1'b0; state_q <= R_WAIT; end
                        8'h84: begin stat_only_q <= 1'b1; state_q <= R_WAIT; end
                        default: begin
                           err_q    <= 1'b1;
                           status_q <= 2'b11;
                           state_q  <= IDLE;
                        end
                     endcase
                  end
               end
               W_WAIT: begin
                  if (!dav_s_q) begin
                     rx_data_q  <= tcbm_data_in;
                     rx_valid_q <= 1'b1;
                     state_q    <= W_PUSH;
                  end
               end
               W_PUSH: begin
                  // ACK is withheld until the byte is taken: host flow control.
                  if (rx_ready) begin
                     rx_valid_q <= 1'b0;
                     ack_q      <= 1'b0;
                     state_q    <= W_REL;
                  end
               end
               W_REL: begin
                  if (dav_s_q) begin
                     ack_q    <= 1'b1;
                     status_q <= 2'b00;
                     state_q  <= IDLE;
                  end
               end
               R_WAIT: begin
                  if (!dav_s_q) begin
                     if (stat_only_q) begin
                        dout_q   <= 8'h00;
                        oe_q     <= 1'b1;
                        status_q <= tx_status;
                        state_q  <= R_ACK;
                     end else if (tx_valid) begin
                        dout_q   <= tx_data;
                        oe_q     <= 1'b1;
                        status_q <= tx_status;
                        state_q  <= R_ACK;
                     end
                  end
               end
               R_ACK: begin
                  // One cycle of data setup on port A before ACK falls.
                  ack_q   <= 1'b0;
                  state_q <= R_REL;
               end
               R_REL: begin
                  if (dav_s_q) begin
                     ack_q      <= 1'b1;
                     oe_q       <= 1'b0;
                     tx_ready_q <= ~stat_only_q;
                     state_q    <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign tcbm_data_out = dout_q;
   assign tcbm_data_oe  = oe_q;
   assign ack_out       = ack_q;
   assign status_out    = status_q;
   assign rx_data       = rx_data_q;
   assign rx_is_cmd     = rx_cmd_q;
   assign rx_valid      = rx_valid_q;
   assign tx_ready      = tx_ready_q;
   assign err           = err_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_tcbm_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for tcbm_handshake_ctrl: a table of host transactions plus hand-written
// sequences for backpressure, delayed tx data, reset mid-read and (when built
// with TCBM_TIMEOUT_EN) the DAV timeout. Inputs change and outputs are read
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tcbm_handshake_ctrl;

   localparam logic [1:0] K_W = 2'd0;   // host writes a byte
   localparam logic [1:0] K_R = 2'd1;   // host reads a byte
   localparam logic [1:0] K_B = 2'd2;   // bad code only

   typedef struct {
      logic [1:0] kind;
      logic [7:0] code;
      logic [7:0] data;
      logic [7:0] tx_data;
      logic [1:0] tx_status;
      logic [1:0] exp_status;
      int         exp_err;
      int         exp_pop;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] tcbm_data_in;
   logic [7:0] tcbm_data_out;
   logic       tcbm_data_oe;
   logic       dav_in;
   logic       ack_out;
   logic [1:0] status_out;
   logic [7:0] rx_data;
   logic       rx_is_cmd;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic [1:0] tx_status;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       err;

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   tcbm_handshake_ctrl #(
      .TIMEOUT_W   (16),
      .TIMEOUT_MAX (16'd100)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .tcbm_data_in  (tcbm_data_in),
      .tcbm_data_out (tcbm_data_out),
      .tcbm_data_oe  (tcbm_data_oe),
      .dav_in        (dav_in),
      .ack_out       (ack_out),
      .status_out    (status_out),
      .rx_data       (rx_data),
      .rx_is_cmd     (rx_is_cmd),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .tx_data       (tx_data),
      .tx_status     (tx_status),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .busy          (busy),
      .err           (err)
   );

   // ---------------- checking ----------------
   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [8:0] exp_q[$];      // {rx_is_cmd, rx_data}
   logic [9:0] exp_rd_q[$];   // {status_out, tcbm_data_out}
   logic [8:0] e_rx;
   logic [9:0] e_rd;
   logic       prev_rx_valid = 1'b0;
   logic       prev_ack      = 1'b1;
   logic       prev_oe       = 1'b0;
   int         err_cnt = 0;
   int         pop_cnt = 0;

   always @(negedge clock) begin
      if (err === 1'b1)      err_cnt++;
      if (tx_ready === 1'b1) pop_cnt++;
      if (rx_valid === 1'b1 && !prev_rx_valid) begin
         if (exp_q.size() == 0) begin
            check("rx_unexpected", 1, 0);
         end else begin
            e_rx = exp_q.pop_front();
            check("rx_byte", {rx_is_cmd, rx_data}, e_rx);
         end
      end
      // ACK falling while the device drives port A: a read byte is presented.
      if (prev_ack && ack_out === 1'b0 && tcbm_data_oe === 1'b1) begin
         check("rd_oe_setup", prev_oe, 1);
         if (exp_rd_q.size() == 0) begin
            check("rd_unexpected", 1, 0);
         end else begin
            e_rd = exp_rd_q.pop_front();
            check("rd_byte", {status_out, tcbm_data_out}, e_rd);
         end
      end
      if (prev_oe && tcbm_data_oe === 1'b0) check("oe_drop_ack_high", ack_out, 1);
      prev_rx_valid = (rx_valid === 1'b1);
      prev_ack      = (ack_out !== 1'b0);
      prev_oe       = (tcbm_data_oe === 1'b1);
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_ack(input logic lvl, input int budget, input string name);
      int n = 0;
      while (ack_out !== lvl && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, ack_out, lvl);
   endtask

   task automatic host_code(input logic [7:0] code);
      tcbm_data_in = code;
      dav_in       = 1'b0;
      wait_ack(1'b0, 20, "code_ack_lo");
      dav_in = 1'b1;
      wait_ack(1'b1, 20, "code_ack_hi");
   endtask

   task automatic host_byte(input logic [7:0] data, input int budget);
      tcbm_data_in = data;
      dav_in       = 1'b0;
      wait_ack(1'b0, budget, "byte_ack_lo");
      dav_in = 1'b1;
      wait_ack(1'b1, 20, "byte_ack_hi");
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int e0 = err_cnt;
      int p0 = pop_cnt;
      case (v.kind)
         K_W: begin
            exp_q.push_back({(v.code == 8'h83), v.data});
            host_code(v.code);
            host_byte(v.data, 20);
         end
         K_R: begin
            tx_data   = v.tx_data;
            tx_status = v.tx_status;
            tx_valid  = 1'b1;
            exp_rd_q.push_back({v.tx_status, (v.code == 8'h84) ? 8'h00 : v.tx_data});
            host_code(v.code);
            host_byte(8'h00, 20);
         end
         default: host_code(v.code);
      endcase
      idle(4);
      tx_valid = 1'b0;
      check($sformatf("vec%0d_status", idx), status_out, v.exp_status);
      check($sformatf("vec%0d_err", idx), err_cnt - e0, v.exp_err);
      check($sformatf("vec%0d_txpop", idx), pop_cnt - p0, v.exp_pop);
      check($sformatf("vec%0d_idle", idx), {busy, rx_valid, tcbm_data_oe, ack_out}, 4'b0001);
      check($sformatf("vec%0d_drained", idx), exp_q.size() + exp_rd_q.size(), 0);
   endtask

   // ---------------- test ----------------
   vec_t vecs[10];

   initial begin
      int bad;
      int p0;
      int n;
      vec_t rv;

      vecs[0] = '{K_W, 8'h81, 8'h5A, 8'h00, 2'b00, 2'b00, 0, 0};
      vecs[1] = '{K_W, 8'h83, 8'h28, 8'h00, 2'b00, 2'b00, 0, 0};
      vecs[2] = '{K_R, 8'h82, 8'h00, 8'hC3, 2'b01, 2'b01, 0, 1};
      vecs[3] = '{K_B, 8'h55, 8'h00, 8'h00, 2'b00, 2'b11, 1, 0};
      vecs[4] = '{K_R, 8'h84, 8'h00, 8'h77, 2'b10, 2'b10, 0, 0};
      vecs[5] = '{K_W, 8'h81, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0};
      vecs[6] = '{K_R, 8'h82, 8'h00, 8'h3C, 2'b11, 2'b11, 0, 1};
      vecs[7] = '{K_B, 8'h00, 8'h00, 8'h00, 2'b00, 2'b11, 1, 0};
      vecs[8] = '{K_W, 8'h83, 8'hFF, 8'h00, 2'b00, 2'b00, 0, 0};
      vecs[9] = '{K_B, 8'h85, 8'h00, 8'h00, 2'b00, 2'b11, 1, 0};

      reset        = 1'b1;
      dav_in       = 1'b1;
      tcbm_data_in = 8'h00;
      rx_ready     = 1'b1;
      tx_data      = 8'h00;
      tx_status    = 2'b00;
      tx_valid     = 1'b0;
      idle(3);

      check("rst_ack",      ack_out, 1);
      check("rst_oe",       tcbm_data_oe, 0);
      check("rst_data_out", tcbm_data_out, 0);
      check("rst_status",   status_out, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_err",      err, 0);
      check("rst_busy",     busy, 0);
      reset = 1'b0;
      idle(2);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Random writes and reads.
      for (int i = 0; i < 6; i++) begin
         rv.kind      = ($urandom_range(0, 1) == 0) ? K_W : K_R;
         rv.data      = 8'($urandom_range(0, 255));
         rv.tx_data   = 8'($urandom_range(0, 255));
         rv.tx_status = 2'($urandom_range(0, 3));
         rv.exp_err   = 0;
         if (rv.kind == K_W) begin
            rv.code       = ($urandom_range(0, 1) == 0) ? 8'h81 : 8'h83;
            rv.exp_status = 2'b00;
            rv.exp_pop    = 0;
         end else begin
            rv.code       = 8'h82;
            rv.exp_status = rv.tx_status;
            rv.exp_pop    = 1;
         end
         run_vec(rv, 10 + i);
      end

      // Backpressure: ACK withheld while rx_ready is low.
      rx_ready = 1'b0;
      exp_q.push_back({1'b0, 8'hA5});
      host_code(8'h81);
      fork
         host_byte(8'hA5, 200);
         begin
            n = 0;
            while (rx_valid !== 1'b1 && n < 20) begin
               @(negedge clock);
               n++;
            end
            check("bp_rx_valid", rx_valid, 1);
            bad = 0;
            repeat (50) begin
               @(negedge clock);
               if (ack_out !== 1'b1 || rx_valid !== 1'b1) bad++;
            end
            check("bp_ack_held", bad, 0);
            rx_ready = 1'b1;
            @(negedge clock);
            check("bp_ack_fall", ack_out, 0);
            check("bp_rx_clear", rx_valid, 0);
         end
      join
      idle(4);
      check("bp_status", status_out, 2'b00);
      check("bp_drained", exp_q.size(), 0);

      // Read with tx_valid arriving late: no ACK and no port drive until then.
      p0        = pop_cnt;
      tx_valid  = 1'b0;
      tx_data   = 8'h96;
      tx_status = 2'b01;
      exp_rd_q.push_back({2'b01, 8'h96});
      host_code(8'h82);
      fork
         host_byte(8'h00, 200);
         begin
            bad = 0;
            repeat (30) begin
               @(negedge clock);
               if (ack_out !== 1'b1 || tcbm_data_oe !== 1'b0) bad++;
            end
            check("late_tx_held", bad, 0);
            tx_valid = 1'b1;
         end
      join
      idle(4);
      tx_valid = 1'b0;
      check("late_tx_pop", pop_cnt - p0, 1);
      check("late_tx_drained", exp_rd_q.size(), 0);

      // Reset while in R_REL: outputs back to reset values next cycle, no pop.
      p0        = pop_cnt;
      tx_valid  = 1'b1;
      tx_data   = 8'hE7;
      tx_status = 2'b10;
      exp_rd_q.push_back({2'b10, 8'hE7});
      host_code(8'h82);
      dav_in = 1'b0;
      wait_ack(1'b0, 20, "rrel_ack_lo");
      check("rrel_oe_before", tcbm_data_oe, 1);
      reset = 1'b1;
      @(negedge clock);
      check("rrel_rst_oe",     tcbm_data_oe, 0);
      check("rrel_rst_ack",    ack_out, 1);
      check("rrel_rst_busy",   busy, 0);
      check("rrel_rst_status", status_out, 0);
      reset  = 1'b0;
      dav_in = 1'b1;
      idle(4);
      tx_valid = 1'b0;
      check("rrel_no_pop", pop_cnt - p0, 0);
      check("rrel_drained", exp_rd_q.size(), 0);

`ifdef TCBM_TIMEOUT_EN
      // Host stops after the code phase: abort after about TIMEOUT_MAX cycles.
      host_code(8'h81);
      n = 0;
      while (err !== 1'b1 && n < 300) begin
         @(negedge clock);
         n++;
      end
      check("tmo_err_seen", err, 1);
      check("tmo_latency", (n >= 95 && n <= 110), 1);
      check("tmo_status", status_out, 2'b10);
      check("tmo_ack", ack_out, 1);
      check("tmo_oe", tcbm_data_oe, 0);
      check("tmo_rx_valid", rx_valid, 0);
      @(negedge clock);
      check("tmo_busy", busy, 0);
      check("tmo_err_pulse", err, 0);
`endif

      // Normal transfer still works afterwards.
      run_vec(vecs[0], 20);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tcbm_handshake_ctrl.md
Name: tcbm_handshake_ctrl

Overview:
Device-side TCBM (1551-style) byte-transfer sequencer that drives the emulated 6523 port lines: data on port A, status on port B[1:0], and the DAV/ACK handshake on port C[7:6].
Decodes the host's transfer code, then moves one data byte host→device or device→host using the two-wire DAV/ACK handshake.
The device side (SD/Arduino bridge) sees plain valid/ready byte streams.
Sits between the port pins and the device-side byte streams.

Parameters:
TIMEOUT_W, 16, width of the handshake timeout counter.
TIMEOUT_MAX, 16'hFFFF, cycles waited for a host DAV edge before aborting.

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high
tcbm_data_in  in  8  port A pins as driven by the host
tcbm_data_out  out  8  port A value driven by the device
tcbm_data_oe  out  1  1 = device drives port A
dav_in  in  1  host DAV (port C7), asynchronous, active-low
ack_out  out  1  device ACK (port C6), active-low
status_out  out  2  port B[1:0] status to the host
rx_data  out  8  byte received from the host
rx_is_cmd  out  1  rx byte came from code 0x83
rx_valid  out  1  rx byte available
rx_ready  in  1  device side accepts the rx byte
tx_data  in  8  byte to send to the host
tx_status  in  2  status sent with tx_data
tx_valid  in  1  tx byte available
tx_ready  out  1  one-cycle pop of the tx byte
busy  out  1  state != IDLE
err  out  1  one-cycle pulse on a bad code or timeout

Behaviour:
- Reset values: ack_out=1, tcbm_data_oe=0, tcbm_data_out=0, status_out=0, rx_valid=0, tx_ready=0, err=0, busy=0. State = IDLE.
- Synchronizer: dav_in passes through a 2-FF synchronizer to give dav_s. Every reference to DAV below means dav_s, so the decision latency is 2 cycles after a pin edge.
- IDLE: on dav_s=0, latch tcbm_data_in as the code, drive ack_out=0, go to CODE_REL.
- CODE_REL: on dav_s=1, drive ack_out=1 and decode the code:
  - 0x81 → W_WAIT, with rx_is_cmd=0.
  - 0x83 → W_WAIT, with rx_is_cmd=1.
  - 0x82 → R_WAIT.
  - 0x84 → R_WAIT, sending tx_status only; no tx pop; data_out=0.
  - Any other code → err pulse, status_out=2'b11, back to IDLE.
- W_WAIT: on dav_s=0, latch tcbm_data_in into rx_data, set rx_valid=1, go to W_PUSH.
- W_PUSH: hold rx_valid=1 until rx_ready=1 (accepted the same cycle). Then clear rx_valid, drive ack_out=0, go to W_REL. ACK is withheld while the device is not ready; this is the flow control to the host.
- W_REL: on dav_s=1, drive ack_out=1, status_out=00, go to IDLE.
- R_WAIT: on dav_s=0, wait for tx_valid=1 (0x82 only). Then drive tcbm_data_out=tx_data, tcbm_data_oe=1, status_out=tx_status, and go to R_ACK.
  - ack_out goes low one cycle after oe, so the data is set up before ACK.
- R_ACK: drive ack_out=0, go to R_REL.
- R_REL: on dav_s=1, drive ack_out=1, tcbm_data_oe=0, pulse tx_ready for one cycle (0x82 only), go to IDLE. status_out holds until the next code.
- Ordering: oe is never deasserted before ACK is released.
- Reset mid-transfer returns every output to its reset value within one cycle. A pending tx byte is not popped.
- The rx stream holds at most one byte; there is no internal FIFO.
- tx_data and tx_status are sampled only in the R_WAIT→R_ACK transition.

Optional Feature:
TCBM_TIMEOUT_EN:
- Defined: a counter clears on every state change and increments while the block waits on a DAV edge. The waiting states are CODE_REL, W_WAIT, W_REL, R_WAIT (before DAV falls), and R_REL.
- At TIMEOUT_MAX: pulse err, ack_out=1, oe=0, rx_valid=0, status_out=2'b10, go to IDLE.
- Waits on rx_ready or tx_valid never time out.
- Undefined: no counter is built, and the block waits forever.

Test Plan:
- Write data: host code 0x81, then byte 0x5A, rx_ready=1 → rx_data=0x5A, rx_is_cmd=0, one ACK low pulse per byte, status_out=00, back to IDLE.
- Command: code 0x83, byte 0x28 → rx_is_cmd=1, rx_data=0x28.
- Backpressure: rx_ready=0 for 50 cycles → ack_out stays high; ACK falls 1 cycle after rx_ready=1.
- Read data: code 0x82, tx_data=0xC3, tx_status=01 → oe=1 with data 0xC3 at least 1 cycle before ACK falls; tx_ready pulses exactly once after DAV rises.
- Bad code 0x55 → err pulse, status_out=11, IDLE, no rx_valid.
- With TCBM_TIMEOUT_EN and TIMEOUT_MAX=100, host stops after the code phase → err at about 100 cycles, status_out=10, ack_out=1. Also: reset asserted in R_REL → oe=0, ack_out=1 on the next cycle.
